// File: rtl/arbiter8_rr_if.sv
// Request/grant bus between eight requesters and the round-robin arbiter.
// The arbiter sits on the slave side; the requesters (or a bench) use master.
interface arbiter8_rr_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_vld,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_vld,
        output timeout
    );
endinterface

// File: rtl/arbiter8_rr.sv
// Eight-way round-robin arbiter with bounded grant hold.
// A grant is issued one cycle after a request is seen in IDLE and is held
// while the grantee keeps its request high, up to MAX_HOLD cycles. After a
// forced release, timeout pulses for one cycle. Every release moves the
// priority pointer just past the released requester. The idle cycle between
// grants is a deliberate part of the protocol, not a pipeline artefact.
module arbiter8_rr #(
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    arbiter8_rr_if.slave  bus
);

    // Reject illegal hold limits at elaboration time.
    generate
        if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
            $error("arbiter8_rr: MAX_HOLD must be in 2..255");
        end
    endgenerate

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q,    state_d;
    logic [2:0] ptr_q,      ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gnt_q,      gnt_d;
    logic [2:0] gnt_id_q,   gnt_id_d;
    logic       gnt_vld_q,  gnt_vld_d;
    logic       timeout_q,  timeout_d;

    logic [2:0] scan_idx;
    logic [2:0] pick_id;
    logic       pick_found;

    // Find the first request at or above ptr, wrapping 7 -> 0.
    always_comb begin
        scan_idx   = '0;
        pick_id    = '0;
        pick_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr_q + 3'(i);
            if (!pick_found && bus.req[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/BUSY machine.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        gnt_vld_d  = gnt_vld_q;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                gnt_d      = '0;
                gnt_id_d   = '0;
                gnt_vld_d  = 1'b0;
                if (pick_found) begin
                    state_d   = BUSY;
                    gnt_d     = 8'b1 << pick_id;
                    gnt_id_d  = pick_id;
                    gnt_vld_d = 1'b1;
                end
            end

            BUSY: begin
                // A dropped request wins over the hold limit: normal release.
                if (!bus.req[gnt_id_q] || hold_cnt_q == HOLD_LAST) begin
                    state_d    = IDLE;
                    ptr_d      = gnt_id_q + 3'd1;
                    hold_cnt_d = '0;
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    gnt_vld_d  = 1'b0;
                    timeout_d  = bus.req[gnt_id_q];
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
                gnt_d      = '0;
                gnt_id_d   = '0;
                gnt_vld_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; synchronous reset drops any grant silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            gnt_vld_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_vld_q  <= gnt_vld_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_arbiter8_rr.sv
// Bench for arbiter8_rr with MAX_HOLD=4: a table of {inputs, expected outputs}
// per clock, a hand-written round-robin sweep, and a scoreboard queue that
// holds the expectation from drive time until the output is sampled.
module tb_arbiter8_rr;

    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst_n;

    arbiter8_rr_if bus ();

    arbiter8_rr #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       vld;
        logic       to;
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       vld;
        logic       to;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic r, input logic [7:0] q,
                                input logic [7:0] g, input logic [2:0] id,
                                input logic v, input logic t, input string nm);
        vec_t x;
        x.rst_n = r; x.req = q; x.gnt = g; x.id = id; x.vld = v; x.to = t; x.name = nm;
        return x;
    endfunction

    // Drive one cycle of inputs, queue the expectation, sample after the edge.
    task automatic step(input logic r, input logic [7:0] q, input logic [7:0] g,
                        input logic [2:0] id, input logic v, input logic t,
                        input string nm);
        exp_t e;
        rst_n   = r;
        bus.req = q;
        e.gnt = g; e.id = id; e.vld = v; e.to = t; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({bus.gnt, bus.gnt_id, bus.gnt_vld, bus.timeout} !== {e.gnt, e.id, e.vld, e.to}) begin
            errors++;
            $display("FAIL %s: got gnt=%b id=%0d vld=%b to=%b, want gnt=%b id=%0d vld=%b to=%b",
                     e.name, bus.gnt, bus.gnt_id, bus.gnt_vld, bus.timeout,
                     e.gnt, e.id, e.vld, e.to);
        end
        checks++;
        if ($countones(bus.gnt) > 1 || bus.gnt[bus.gnt_id] !== bus.gnt_vld ||
            (!bus.gnt_vld && bus.gnt_id != 3'd0)) begin
            errors++;
            $display("FAIL inv_%s: got gnt=%b id=%0d vld=%b, want one-hot with gnt[id]==vld",
                     e.name, bus.gnt, bus.gnt_id, bus.gnt_vld);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        bus.req = '0;

        // Reset with all requests pending, then first grant to requester 0.
        vecs.push_back(mk(0, 8'hFF, 8'h00, 0, 0, 0, "rst0"));
        vecs.push_back(mk(0, 8'hFF, 8'h00, 0, 0, 0, "rst1"));
        vecs.push_back(mk(1, 8'hFF, 8'h01, 0, 1, 0, "rst_first_gnt"));
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, "rel0"));            // ptr=1
        // Idle with no request stays idle.
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, "idle"));
        // Single request.
        vecs.push_back(mk(1, 8'h04, 8'h04, 2, 1, 0, "single_gnt"));
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, "single_rel"));      // ptr=3
        // Timeout: 4 grant cycles, one timeout cycle, then regrant.
        vecs.push_back(mk(1, 8'h08, 8'h08, 3, 1, 0, "to_h0"));
        vecs.push_back(mk(1, 8'h08, 8'h08, 3, 1, 0, "to_h1"));
        vecs.push_back(mk(1, 8'h08, 8'h08, 3, 1, 0, "to_h2"));
        vecs.push_back(mk(1, 8'h08, 8'h08, 3, 1, 0, "to_h3"));
        vecs.push_back(mk(1, 8'h08, 8'h00, 0, 0, 1, "to_pulse"));        // ptr=4
        vecs.push_back(mk(1, 8'h08, 8'h08, 3, 1, 0, "to_regrant"));
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, "to_rel"));          // ptr=4
        // Move ptr to 3 via requester 2.
        vecs.push_back(mk(1, 8'h04, 8'h04, 2, 1, 0, "ptr3_gnt"));
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, "ptr3_rel"));        // ptr=3
        // Timeout fairness: 3 timed out, then 0 wins over 3.
        vecs.push_back(mk(1, 8'h09, 8'h08, 3, 1, 0, "fair_h0"));
        vecs.push_back(mk(1, 8'h09, 8'h08, 3, 1, 0, "fair_h1"));
        vecs.push_back(mk(1, 8'h09, 8'h08, 3, 1, 0, "fair_h2"));
        vecs.push_back(mk(1, 8'h09, 8'h08, 3, 1, 0, "fair_h3"));
        vecs.push_back(mk(1, 8'h09, 8'h00, 0, 0, 1, "fair_pulse"));      // ptr=4
        vecs.push_back(mk(1, 8'h09, 8'h01, 0, 1, 0, "fair_gnt0"));
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, "fair_rel"));        // ptr=1
        // Drop on the last allowed cycle counts as a normal release.
        vecs.push_back(mk(1, 8'h10, 8'h10, 4, 1, 0, "late_h0"));
        vecs.push_back(mk(1, 8'h10, 8'h10, 4, 1, 0, "late_h1"));
        vecs.push_back(mk(1, 8'h10, 8'h10, 4, 1, 0, "late_h2"));
        vecs.push_back(mk(1, 8'h10, 8'h10, 4, 1, 0, "late_h3"));
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, "late_rel_no_to"));  // ptr=5
        // Other requests do not disturb a grant; then reset mid-grant.
        vecs.push_back(mk(1, 8'h20, 8'h20, 5, 1, 0, "busy_gnt5"));
        vecs.push_back(mk(1, 8'hFF, 8'h20, 5, 1, 0, "busy_others"));
        vecs.push_back(mk(1, 8'hFF, 8'h20, 5, 1, 0, "busy_others2"));
        vecs.push_back(mk(0, 8'h20, 8'h00, 0, 0, 0, "midrst"));          // ptr=0
        vecs.push_back(mk(1, 8'hA0, 8'h20, 5, 1, 0, "midrst_regrant"));
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, "midrst_rel"));

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst_n, vecs[i].req, vecs[i].gnt, vecs[i].id,
                 vecs[i].vld, vecs[i].to, vecs[i].name);

        // Round robin sweep: each grantee holds 3 cycles, drops, reasserts.
        step(0, 8'h00, 8'h00, 0, 0, 0, "rr_rst");
        for (int k = 0; k < 9; k++) begin
            logic [2:0] id;
            logic [7:0] oh;
            id = 3'(k % 8);
            oh = 8'b1 << id;
            step(1, 8'hFF,  oh, id, 1, 0, $sformatf("rr%0d_gnt", k));
            step(1, 8'hFF,  oh, id, 1, 0, $sformatf("rr%0d_h1", k));
            step(1, 8'hFF,  oh, id, 1, 0, $sformatf("rr%0d_h2", k));
            step(1, ~oh, 8'h00, 0, 0, 0, $sformatf("rr%0d_idle", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbiter8_rr.md
ARBITER8_RR -- requirements
Module: arbiter8_rr

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive cycles one grant is held; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock; the block has a single clock.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 req  input  8  request lines; req[k] high = requester k wants the shared resource and holds it high while using it.
REQ-005 gnt  output  8  one-hot grant, registered.
REQ-006 gnt_id  output  3  binary index of the granted requester, registered.
REQ-007 gnt_vld  output  1  high when gnt is non-zero, registered.
REQ-008 timeout  output  1  one-cycle pulse, registered; high in the cycle after a grant is force-released.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant held).
REQ-010 In IDLE, if req != 0 at a rising edge, the block SHALL select the first set req bit scanning upward from ptr, wrapping 7->0, and enter BUSY.
REQ-011 The selected requester's gnt bit, its gnt_id and gnt_vld SHALL all be high in the cycle immediately after that edge, giving 1-cycle latency.
REQ-012 In IDLE with req == 0, the block SHALL stay in IDLE with gnt=0, gnt_id=0, gnt_vld=0.
REQ-013 gnt SHALL always be zero or one-hot, and gnt[gnt_id] SHALL equal gnt_vld.
REQ-014 gnt_id SHALL be 0 whenever gnt_vld=0.
REQ-015 In BUSY, hold_cnt (8 bits) SHALL be 0 in the first grant cycle and SHALL increment by 1 each cycle the grant is held.
REQ-016 In BUSY, if req[gnt_id]=0 at an edge, the next cycle SHALL have gnt=0, gnt_vld=0 and timeout=0, and the state SHALL return to IDLE.
REQ-017 In BUSY, if req[gnt_id]=1 and hold_cnt==MAX_HOLD-1 at an edge, the next cycle SHALL have gnt=0, gnt_vld=0 and timeout=1, and the state SHALL return to IDLE.
REQ-018 As a consequence of REQ-015 to REQ-017, gnt SHALL be high for at most MAX_HOLD consecutive cycles.
REQ-019 Requests from other requesters while in BUSY SHALL NOT affect the current grant.
REQ-020 On each grant release, whether normal or timeout, ptr SHALL become (released gnt_id + 1) mod 8, so the releasing requester has lowest priority next.
REQ-021 At least one cycle with gnt_vld=0 SHALL separate any two grants; back-to-back grants without an idle cycle are prohibited.
REQ-022 timeout SHALL be 0 in every cycle other than the one defined in REQ-017.
REQ-023 If the granted req drops in the same cycle that hold_cnt==MAX_HOLD-1, the release SHALL be treated as normal (timeout=0).

Reset
REQ-024 rst_n=0 at a rising edge SHALL force state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_id=0, gnt_vld=0 and timeout=0 on the next cycle, regardless of req.
REQ-025 A reset asserted mid-grant SHALL drop the grant on the next cycle without a timeout pulse.
REQ-026 After reset, requester 0 SHALL have highest priority.
REQ-027 The first arbitration after rst_n returns high SHALL occur at the first edge with rst_n=1 and req != 0.

Verification
REQ-028 Reset test: rst_n=0 for 2 cycles with req=8'hFF -> gnt=0, gnt_id=0, gnt_vld=0, timeout=0 throughout; after rst_n=1, next cycle gnt=8'h01, gnt_id=0.
REQ-029 Single request: req=8'b00000100 from idle -> next cycle gnt=8'b00000100, gnt_id=3'd2, gnt_vld=1; clear req -> next cycle gnt=0, gnt_vld=0, timeout=0.
REQ-030 Round robin: req=8'hFF, each grantee drops its bit 3 cycles after grant then reasserts -> grant order 0,1,2,...,7,0, with exactly one idle cycle between grants.
REQ-031 Timeout with MAX_HOLD=4: req=8'h08 held high -> gnt=8'h08 for exactly 4 cycles; then 1 cycle with gnt=0, timeout=1; then gnt=8'h08 again.
REQ-032 Timeout fairness with MAX_HOLD=4: req=8'h09 held high with ptr=3 -> requester 3 granted 4 cycles, timeout pulse, then requester 0 granted.
REQ-033 Mid-grant reset: requester 5 granted, rst_n=0 for 1 cycle -> next cycle gnt=0, timeout=0; with req=8'hA0 after reset -> requester 5 granted (ptr=0, scan upward).
